// File: rtl/regfile_mp.sv
// regfile_mp: 2R/2W parametrised integer register file with write-to-read bypass and a bulk-clear sweep.
// Latency: reads are combinational (zero cycles); writes land at the rising edge; a clear takes NREGS+1 cycles to the done pulse.
// Backpressure: none; while the clear sweep runs, both write ports are ignored and reads see raw array contents.
// Optional debug read port: define REGFILE_MP_DBG_EN to add dbg_addr/dbg_data (registered, 1-cycle latency, no bypass).

module regfile_mp #(
    parameter int XLEN     = 32,
    parameter int NREGS    = 32,
    parameter int AW       = 5,
    parameter int ZERO_REG = 1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            we0,
    input  logic [AW-1:0]   waddr0,
    input  logic [XLEN-1:0] wdata0,
    input  logic            we1,
    input  logic [AW-1:0]   waddr1,
    input  logic [XLEN-1:0] wdata1,
    input  logic [AW-1:0]   rs1,
    input  logic [AW-1:0]   rs2,
    output logic [XLEN-1:0] rdata1,
    output logic [XLEN-1:0] rdata2,
    input  logic            clr_req,
    output logic            clr_busy,
    output logic            clr_done
`ifdef REGFILE_MP_DBG_EN
    ,
    input  logic [AW-1:0]   dbg_addr,
    output logic [XLEN-1:0] dbg_data
`endif
);

    // Register 0 is hardwired to zero only when ZERO_REG is non-zero.
    localparam bit          ZR       = (ZERO_REG != 0);
    // Pointer value of the last register in the sweep.
    localparam logic [AW-1:0] LAST_PTR = AW'(NREGS - 1);
    localparam logic [AW-1:0] PTR_ONE  = AW'(1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_CLEAR = 2'd1,
        S_DONE  = 2'd2
    } clr_state_t;

    clr_state_t      state;
    logic [AW-1:0]   ptr;
    logic [XLEN-1:0] regs [NREGS];

    logic sweeping;
    logic wr0;
    logic wr1;

    // Qualified write enables: the sweep owns the array, and x0 writes vanish when hardwired.
    always_comb begin
        sweeping = (state == S_CLEAR);
        wr0      = we0 && !sweeping && !(ZR && (waddr0 == '0));
        wr1      = we1 && !sweeping && !(ZR && (waddr1 == '0));
    end

    // Clear sequencer: IDLE -> CLEAR (one register per cycle) -> DONE (one-cycle pulse) -> IDLE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= S_IDLE;
            ptr      <= '0;
            clr_busy <= 1'b0;
            clr_done <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    clr_done <= 1'b0;
                    if (clr_req) begin
                        state    <= S_CLEAR;
                        ptr      <= '0;
                        clr_busy <= 1'b1;
                    end
                end
                S_CLEAR: begin
                    // Requests arriving mid-sweep are dropped, not queued.
                    if (ptr == LAST_PTR) begin
                        state    <= S_DONE;
                        clr_busy <= 1'b0;
                        clr_done <= 1'b1;
                    end else begin
                        ptr <= ptr + PTR_ONE;
                    end
                end
                S_DONE: begin
                    state    <= S_IDLE;
                    clr_done <= 1'b0;
                    clr_busy <= 1'b0;
                end
                default: begin
                    state    <= S_IDLE;
                    ptr      <= '0;
                    clr_busy <= 1'b0;
                    clr_done <= 1'b0;
                end
            endcase
        end
    end

    // Array update: sweep zeroes one entry per edge; otherwise port 1 is written last so it wins a collision.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREGS; i++) begin
                regs[i] <= '0;
            end
        end else if (sweeping) begin
            regs[ptr] <= '0;
        end else begin
            if (wr0) begin
                regs[waddr0] <= wdata0;
            end
            if (wr1) begin
                regs[waddr1] <= wdata1;
            end
        end
    end

    // Read port A: hardwired zero, then port-1 bypass, then port-0 bypass, then the array.
    always_comb begin
        rdata1 = regs[rs1];
        if (ZR && (rs1 == '0)) begin
            rdata1 = '0;
        end else if (wr1 && (waddr1 == rs1)) begin
            rdata1 = wdata1;
        end else if (wr0 && (waddr0 == rs1)) begin
            rdata1 = wdata0;
        end
    end

    // Read port B: same priority as port A.
    always_comb begin
        rdata2 = regs[rs2];
        if (ZR && (rs2 == '0)) begin
            rdata2 = '0;
        end else if (wr1 && (waddr1 == rs2)) begin
            rdata2 = wdata1;
        end else if (wr0 && (waddr0 == rs2)) begin
            rdata2 = wdata0;
        end
    end

`ifdef REGFILE_MP_DBG_EN
    // Debug snapshot: samples the pre-edge array contents, deliberately without bypass.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dbg_data <= '0;
        end else begin
            dbg_data <= regs[dbg_addr];
        end
    end
`endif

endmodule
